id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the decode control unit.
- Latches the WB/M/EX control bundles, register operands, immediate and PC+4 each cycle.
- Contains the load-use hazard detector. On a hazard it stalls IF/ID and inserts a bubble.
- Supports branch/jump flush and a memory-busy hold.

---
 rtl/id_ex_stage.sv | 95 +++++++++
 tb/tb_id_ex_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush and memory hold.
// Optional bubble counter enabled by defining ID_EX_HAZARD_STATS_EN.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [1:0]    id_WB,
    input  logic [3:0]    id_M,
    input  logic [7:0]    id_EX,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic          flush,
    input  logic          mem_hold,
    output logic          ex_valid,
    output logic [1:0]    ex_WB,
    output logic [3:0]    ex_M,
    output logic [7:0]    ex_EX,
    output logic          ex_ALUSrc,
    output logic [5:0]    ex_ALUOp,
    output logic          ex_RegDst,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_rd,
    output logic [RW-1:0] ex_dst,
    output logic [DW-1:0] ex_rdata1,
    output logic [DW-1:0] ex_rdata2,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic          stall,
    output logic [15:0]   bubble_count
);
    logic load_use, bubble, live;

    // a store's rt is exempt because its data is forwarded later in the pipe
    assign load_use = ex_valid && ex_M[3:2] != 2'b00 && ex_rt != '0 && id_valid &&
                      (ex_rt == id_rs || (ex_rt == id_rt && id_M[1:0] == 2'b00));
    assign stall    = load_use | mem_hold;
    assign bubble   = flush | load_use;
    assign live     = id_valid & ~bubble;

    assign ex_ALUSrc = ex_EX[7];
    assign ex_ALUOp  = ex_EX[6:1];
    assign ex_RegDst = ex_EX[0];
    assign ex_dst    = ex_RegDst ? ex_rd : ex_rt;

    // pipeline register: reset, then hold, then bubble (controls zeroed), then normal load
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_WB     <= '0;
            ex_M      <= '0;
            ex_EX     <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_rdata1 <= '0;
            ex_rdata2 <= '0;
            ex_imm    <= '0;
            ex_pc4    <= '0;
        end else if (!mem_hold) begin
            ex_valid  <= live;
            ex_WB     <= live ? id_WB : '0;
            ex_M      <= live ? id_M : '0;
            ex_EX     <= live ? id_EX : '0;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            ex_rdata1 <= id_rdata1;
            ex_rdata2 <= id_rdata2;
            ex_imm    <= id_imm;
            ex_pc4    <= id_pc4;
        end
    end

`ifdef ID_EX_HAZARD_STATS_EN
    // saturating count of bubbles actually loaded into EX
    always_ff @(posedge clk) begin
        if (rst)
            bubble_count <= '0;
        else if (!mem_hold && bubble && bubble_count != 16'hFFFF)
            bubble_count <= bubble_count + 16'd1;
    end
`else
    assign bubble_count = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for the ID/EX stage and its hazard logic.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst, id_valid, flush, mem_hold;
    logic [1:0]  id_WB;
    logic [3:0]  id_M;
    logic [7:0]  id_EX;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic        ex_valid, ex_ALUSrc, ex_RegDst, stall;
    logic [1:0]  ex_WB;
    logic [3:0]  ex_M;
    logic [7:0]  ex_EX;
    logic [5:0]  ex_ALUOp;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_dst;
    logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic [15:0] bubble_count;
    int checks = 0;
    int errors = 0;

`ifdef ID_EX_HAZARD_STATS_EN
    localparam bit stats = 1'b1;
`else
    localparam bit stats = 1'b0;
`endif

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_WB(id_WB), .id_M(id_M), .id_EX(id_EX),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm(id_imm), .id_pc4(id_pc4), .flush(flush), .mem_hold(mem_hold),
        .ex_valid(ex_valid), .ex_WB(ex_WB), .ex_M(ex_M), .ex_EX(ex_EX), .ex_ALUSrc(ex_ALUSrc),
        .ex_ALUOp(ex_ALUOp), .ex_RegDst(ex_RegDst), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_dst(ex_dst), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_pc4(ex_pc4), .stall(stall), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic set_id(input logic v, input logic [1:0] wb, input logic [3:0] m,
                          input logic [7:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] imm);
        id_valid  = v;
        id_WB     = wb;
        id_M      = m;
        id_EX     = ex;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        id_imm    = imm;
        id_rdata1 = {27'd0, rs} + 32'd100;
        id_rdata2 = {27'd0, rt} + 32'd200;
        id_pc4    = imm + 32'h1000;
        #1;
    endtask

    function automatic logic [31:0] cnt(input int n);
        return stats ? n : 0;
    endfunction

    initial begin
        // reset with random ID inputs
        rst = 1'b1; flush = 1'b0; mem_hold = 1'b0;
        id_valid = 1'b1; id_WB = 2'($urandom); id_M = 4'($urandom); id_EX = 8'($urandom);
        id_rs = 5'($urandom); id_rt = 5'($urandom); id_rd = 5'($urandom);
        id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom; id_pc4 = $urandom;
        tick();
        tick();
        chk("rst_valid", ex_valid, 0);
        chk("rst_WB", ex_WB, 0);
        chk("rst_M", ex_M, 0);
        chk("rst_EX", ex_EX, 0);
        chk("rst_rdata1", ex_rdata1, 0);
        chk("rst_pc4", ex_pc4, 0);
        chk("rst_dst", ex_dst, 0);
        chk("rst_stall", stall, 0);
        chk("rst_count", bubble_count, 0);
        rst = 1'b0;

        // addi pass-through
        set_id(1, 2'b01, 4'b0000, 8'b1_001000_0, 5'd1, 5'd5, 5'd0, 32'd7);
        chk("addi_stall", stall, 0);
        tick();
        chk("addi_alusrc", ex_ALUSrc, 1);
        chk("addi_aluop", ex_ALUOp, 6'b001000);
        chk("addi_dst", ex_dst, 5);
        chk("addi_imm", ex_imm, 7);
        chk("addi_valid", ex_valid, 1);
        chk("addi_WB", ex_WB, 2'b01);
        chk("addi_pc4", ex_pc4, 32'h1007);
        chk("addi_rdata1", ex_rdata1, 101);

        // lw r8 then add using rs=8
        set_id(1, 2'b11, 4'b0100, 8'b1_000000_0, 5'd1, 5'd8, 5'd0, 32'd4);
        chk("lw8_stall", stall, 0);
        tick();
        set_id(1, 2'b01, 4'b0000, 8'b0_000000_1, 5'd8, 5'd3, 5'd10, 32'd0);
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_WB", ex_WB, 0);
        chk("lu_bub_M", ex_M, 0);
        chk("lu_bub_EX", ex_EX, 0);
        chk("lu_count", bubble_count, cnt(1));
        chk("lu_stall_once", stall, 0);
        tick();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_dst", ex_dst, 10);
        chk("lu_add_rs", ex_rs, 8);
        chk("lu_add_EX", ex_EX, 8'b0_000000_1);

        // store exemption: lw r9 then sw rt=9
        set_id(1, 2'b11, 4'b0100, 8'b1_000000_0, 5'd1, 5'd9, 5'd0, 32'd8);
        tick();
        set_id(1, 2'b00, 4'b0001, 8'b1_000000_0, 5'd2, 5'd9, 5'd0, 32'd12);
        chk("sw_stall", stall, 0);
        tick();
        chk("sw_valid", ex_valid, 1);
        chk("sw_M", ex_M, 4'b0001);

        // lw r0 then add using r0
        set_id(1, 2'b11, 4'b0100, 8'b1_000000_0, 5'd1, 5'd0, 5'd0, 32'd16);
        tick();
        set_id(1, 2'b01, 4'b0000, 8'b0_000000_1, 5'd0, 5'd0, 5'd11, 32'd0);
        chk("r0_stall", stall, 0);
        tick();
        chk("r0_valid", ex_valid, 1);

        // byte load r12 then add using rt=12
        set_id(1, 2'b11, 4'b1000, 8'b1_000000_0, 5'd1, 5'd12, 5'd0, 32'd20);
        tick();
        set_id(1, 2'b01, 4'b0000, 8'b0_000000_1, 5'd1, 5'd12, 5'd13, 32'd0);
        chk("rt_stall", stall, 1);
        tick();
        chk("rt_bub_valid", ex_valid, 0);
        chk("rt_count", bubble_count, cnt(2));
        chk("rt_stall_once", stall, 0);
        tick();
        chk("rt_add_dst", ex_dst, 13);

        // flush of a beq
        set_id(1, 2'b00, 4'b0000, 8'b0_000001_0, 5'd4, 5'd5, 5'd0, 32'd24);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", ex_valid, 0);
        chk("fl_M", ex_M, 0);
        chk("fl_EX", ex_EX, 0);
        chk("fl_count", bubble_count, cnt(3));

        // flush together with load-use
        set_id(1, 2'b11, 4'b0100, 8'b1_000000_0, 5'd1, 5'd14, 5'd0, 32'd28);
        tick();
        set_id(1, 2'b01, 4'b0000, 8'b0_000000_1, 5'd14, 5'd2, 5'd15, 32'd0);
        flush = 1'b1;
        #1;
        chk("flu_stall", stall, 1);
        tick();
        flush = 1'b0;
        chk("flu_valid", ex_valid, 0);
        chk("flu_count", bubble_count, cnt(4));
        set_id(1, 2'b01, 4'b0000, 8'b1_001101_0, 5'd3, 5'd6, 5'd0, 32'd33);
        tick();
        chk("flu_next_valid", ex_valid, 1);
        chk("flu_next_imm", ex_imm, 33);
        chk("flu_count_keep", bubble_count, cnt(4));

        // mem_hold mid-stall: lw r15 in EX, dependent add in ID
        set_id(1, 2'b11, 4'b0100, 8'b1_000000_0, 5'd1, 5'd15, 5'd0, 32'd40);
        tick();
        set_id(1, 2'b01, 4'b0000, 8'b0_000000_1, 5'd15, 5'd2, 5'd16, 32'd0);
        mem_hold = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_stall", stall, 1);
            tick();
            chk("hold_M", ex_M, 4'b0100);
            chk("hold_rt", ex_rt, 15);
            chk("hold_imm", ex_imm, 40);
            chk("hold_valid", ex_valid, 1);
            chk("hold_count", bubble_count, cnt(4));
        end
        mem_hold = 1'b0;
        #1;
        chk("rel_stall", stall, 1);
        tick();
        chk("rel_bub_valid", ex_valid, 0);
        chk("rel_count", bubble_count, cnt(5));
        tick();
        chk("rel_add_valid", ex_valid, 1);
        chk("rel_add_rs", ex_rs, 15);
        chk("rel_add_dst", ex_dst, 16);

        // invalid ID slot loads zero controls
        set_id(0, 2'b11, 4'b0101, 8'hFF, 5'd7, 5'd7, 5'd7, 32'd44);
        tick();
        chk("inv_valid", ex_valid, 0);
        chk("inv_WB", ex_WB, 0);
        chk("inv_imm", ex_imm, 44);

        // reset mid-run overrides a valid instruction and clears the counter
        set_id(1, 2'b01, 4'b0000, 8'b1_001000_0, 5'd1, 5'd5, 5'd0, 32'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_valid", ex_valid, 0);
        chk("rst2_imm", ex_imm, 0);
        chk("rst2_count", bubble_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
